// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM multi-digit 7-segment display controller.
// Optional macro HEXDISP_OUTSNAP_EN exposes out_port/phase at addresses 14/15.
module hex_display_ctrl #(
    parameter int          DIGITS         = 4,
    parameter logic [31:0] RESET_DIV      = 32'd25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DIGITS*8-1:0]   out_port
);

    localparam int          VW       = 4 * DIGITS;
    localparam logic [7:0]  OFF_BYTE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic                  wr;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [VW-1:0]         value_q, value_d;
    logic [7:0]            seg_q [DIGITS];
    logic [7:0]            seg_d [DIGITS];
    logic [DIGITS*8-1:0]   out_q, out_d;

    assign wr       = chipselect && !write_n;
    assign out_port = out_q;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Register file updates from bus writes
    always_comb begin
        ctrl_d  = ctrl_q;
        mask_d  = mask_q;
        div_d   = div_q;
        value_d = value_q;
        seg_d   = seg_q;
        if (wr) begin
            case (address)
                4'd0:    ctrl_d  = writedata[2:0];
                4'd1:    mask_d  = writedata[DIGITS-1:0];
                4'd2:    div_d   = writedata;
                4'd3:    value_d = writedata[VW-1:0];
                default: ;
            endcase
            for (int d = 0; d < DIGITS; d++) begin
                if (address == 4'(4 + d)) seg_d[d] = writedata[7:0];
            end
        end
    end

    // Blink prescaler: a DIV write or CTRL-driven restart beats expiry
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && address == 4'd2) begin
            cnt_d   = writedata;
            phase_d = 1'b1;
        end else if (wr && address == 4'd0
                     && (!writedata[1] || !ctrl_q[1])) begin
            cnt_d   = div_q;
            phase_d = 1'b1;
        end else if (ctrl_q[1] && div_q != 32'd0) begin
            if (cnt_q == 32'd0) begin
                cnt_d   = div_q;
                phase_d = !phase_q;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
    end

    // Compose each digit, apply blank/blink gating and pin polarity
    always_comb begin
        logic [7:0] lvl;
        lvl   = 8'h00;
        out_d = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (ctrl_q[0]) lvl = {seg_q[d][7], dec7(value_q[4*d +: 4])};
            else           lvl = seg_q[d];
            if (ctrl_q[2] || (ctrl_q[1] && mask_q[d] && !phase_q))
                lvl = 8'h00;
            out_d[8*d +: 8] = SEG_ACTIVE_LOW ? ~lvl : lvl;
        end
    end

`ifdef HEXDISP_OUTSNAP_EN
    logic [63:0] out_ext;
    assign out_ext = 64'(out_q);
`endif

    // Zero-wait-state read mux, decoded from address alone
    always_comb begin
        readdata = '0;
        case (address)
            4'd0:    readdata[2:0]        = ctrl_q;
            4'd1:    readdata[DIGITS-1:0] = mask_q;
            4'd2:    readdata             = div_q;
            4'd3:    readdata[VW-1:0]     = value_q;
`ifdef HEXDISP_OUTSNAP_EN
            4'd14:   readdata = out_ext[31:0];
            4'd15: begin
                readdata     = out_ext[63:32];
                readdata[31] = phase_q;
            end
`endif
            default: ;
        endcase
        for (int d = 0; d < DIGITS; d++) begin
            if (address == 4'(4 + d)) readdata[7:0] = seg_q[d];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            mask_q  <= '0;
            div_q   <= RESET_DIV;
            value_q <= '0;
            cnt_q   <= RESET_DIV;
            phase_q <= 1'b1;
            out_q   <= {DIGITS{OFF_BYTE}};
            for (int d = 0; d < DIGITS; d++) seg_q[d] <= 8'h00;
        end else begin
            ctrl_q  <= ctrl_d;
            mask_q  <= mask_d;
            div_q   <= div_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            seg_q   <= seg_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: scoreboard bench for hex_display_ctrl (DIGITS=4,
// active-low pins) with a cycle-stamp reference model of the blink phase.
module tb_hex_display_ctrl;

    localparam logic [31:0] RD = 32'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;

    hex_display_ctrl #(
        .DIGITS(4),
        .RESET_DIV(RD),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] out_exp_q [$];
    logic [31:0] rd_exp_q  [$];
    logic [3:0]  rd_addr_q [$];

    logic [6:0] dec_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference state: registers plus the edge count of the last restart
    logic [2:0]  m_ctrl;
    logic [3:0]  m_mask;
    logic [31:0] m_div;
    logic [15:0] m_value;
    logic [7:0]  m_seg [4];
    logic [31:0] m_out;
    longint      cyc  = 0;
    longint      m_rs = 0;

    // Phase is on during even-numbered half-periods of length DIV+1
    function automatic bit m_phase();
        if (!m_ctrl[1] || m_div == 0) return 1'b1;
        return (((cyc - m_rs) / (longint'(m_div) + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_compose();
        logic [31:0] o = '0;
        logic [7:0]  v;
        bit ph = m_phase();
        for (int d = 0; d < 4; d++) begin
            v = m_ctrl[0] ? {m_seg[d][7], dec_tbl[m_value[4*d +: 4]]}
                          : m_seg[d];
            if (m_ctrl[2] || (m_ctrl[1] && m_mask[d] && !ph)) v = 8'h00;
            o[8*d +: 8] = ~v;
        end
        return o;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return {29'b0, m_ctrl};
            4'd1: return {28'b0, m_mask};
            4'd2: return m_div;
            4'd3: return {16'b0, m_value};
            4'd4, 4'd5, 4'd6, 4'd7: return {24'b0, m_seg[a - 4'd4]};
`ifdef HEXDISP_OUTSNAP_EN
            4'd14: return m_out;
            4'd15: return {m_phase(), 31'b0};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_reset();
        m_ctrl  = '0;
        m_mask  = '0;
        m_div   = RD;
        m_value = '0;
        for (int d = 0; d < 4; d++) m_seg[d] = 8'h00;
        m_rs = cyc;
    endfunction

    function automatic void m_write(input logic [3:0] a,
                                    input logic [31:0] d);
        case (a)
            4'd0: begin
                if (!d[1] || !m_ctrl[1]) m_rs = cyc;
                m_ctrl = d[2:0];
            end
            4'd1: m_mask = d[3:0];
            4'd2: begin
                m_div = d;
                m_rs  = cyc;
            end
            4'd3: m_value = d[15:0];
            4'd4, 4'd5, 4'd6, 4'd7: m_seg[a - 4'd4] = d[7:0];
            default: ;
        endcase
    endfunction

    // One bus cycle: drive, predict, advance the model past the edge
    task automatic step(input bit rst, input bit cs, input bit wn,
                        input logic [3:0] a, input logic [31:0] d);
        logic [31:0] nxt;
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        if (cs && wn && !rst) begin
            rd_exp_q.push_back(m_read(a));
            rd_addr_q.push_back(a);
        end
        nxt = rst ? 32'hFFFF_FFFF : m_compose();
        @(posedge clk);
        cyc++;
        if (rst) m_reset();
        else if (cs && !wn) m_write(a, d);
        m_out = nxt;
        #1;
        out_exp_q.push_back(nxt);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
    endtask

    // Monitor: compare whatever the scoreboard expects this cycle
    always @(negedge clk) begin
        logic [31:0] e;
        logic [3:0]  a;
        if (out_exp_q.size() > 0) begin
            e = out_exp_q.pop_front();
            tests++;
            if (out_port !== e) begin
                fails++;
                $display("FAIL out_port t=%0t got %h exp %h",
                         $time, out_port, e);
            end
        end
        if (rd_exp_q.size() > 0) begin
            e = rd_exp_q.pop_front();
            a = rd_addr_q.pop_front();
            tests++;
            if (readdata !== e) begin
                fails++;
                $display("FAIL readdata addr=%0d t=%0t got %h exp %h",
                         a, $time, readdata, e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        int          r;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = '0; writedata = '0;

        step(1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 4'd0, 32'd0);
        for (int i = 0; i < 4; i++) rd(4'(i));

        wr(4'd4, 32'h3F);
        wr(4'd5, 32'h86);
        idle(2);
        rd(4'd5);

        wr(4'd3, 32'h0000_A5F3);
        wr(4'd0, 32'h1);
        idle(2);
        wr(4'd6, 32'h80);
        idle(2);

        wr(4'd2, 32'd3);
        wr(4'd1, 32'h2);
        wr(4'd0, 32'h3);
        idle(13);
        wr(4'd2, 32'd3);
        idle(6);

        wr(4'd0, 32'h4);
        wr(4'd7, 32'h5A);
        idle(2);
        wr(4'd0, 32'h1);
        idle(2);

        wr(4'd9, 32'hFF);
        rd(4'd9);
        rd(4'd12);
        rd(4'd14);
        rd(4'd15);
        step(1'b0, 1'b0, 1'b0, 4'd4, 32'h11);
        rd(4'd4);

        wr(4'd0, 32'h3);
        idle(5);
        step(1'b1, 1'b1, 1'b0, 4'd4, 32'h55);
        for (int i = 0; i < 8; i++) rd(4'(i));
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 4'd0)
                d = (d & 32'hFFFF_FFFB)
                  | (($urandom_range(0, 4) == 0) ? 32'h4 : 32'h0);
            if (a == 4'd2 && $urandom_range(0, 9) != 0)
                d = 32'($urandom_range(0, 6));
            if (r < 2)       step(1'b1, 1'($urandom), 1'($urandom), a, d);
            else if (r < 40) wr(a, d);
            else if (r < 70) rd(a);
            else             step(1'b0, 1'($urandom), 1'b1, a, d);
        end

        idle(2);
        @(negedge clk);
        #1;
        if (out_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: out %0d rd %0d left, need 0",
                     out_exp_q.size(), rd_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
